// File: rtl/tomasulo_pkg.sv
// Shared opcode constants, field widths and instruction-class decode for the
// Tomasulo issue stage.
package tomasulo_pkg;
  localparam int REG_W     = 4;
  localparam int ROB_TAG_W = 3;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_LD  = 4'b0100;
  localparam logic [3:0] OP_ST  = 4'b0101;
  localparam logic [3:0] OP_BR0 = 4'b0110;
  localparam logic [3:0] OP_BR1 = 4'b0111;

  function automatic logic is_legal(input logic [3:0] f);
    return !f[3];
  endfunction

  function automatic logic is_add_class(input logic [3:0] f);
    return f == OP_ADD || f == OP_SUB || f == OP_LD || f == OP_ST ||
           f == OP_BR0 || f == OP_BR1;
  endfunction

  function automatic logic is_mul_class(input logic [3:0] f);
    return f == OP_MUL || f == OP_DIV;
  endfunction

  function automatic logic writes_rd(input logic [3:0] f);
    return f == OP_ADD || f == OP_SUB || f == OP_MUL || f == OP_DIV || f == OP_LD;
  endfunction
endpackage

// File: rtl/reg_status_table.sv
// Register status table: busy bit plus producing ROB tag per architectural
// register, two bypassed read ports, one rename write and one commit clear.
module reg_status_table
  import tomasulo_pkg::*;
#(
  parameter int NREG = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic [REG_W-1:0]     rs1_addr,
  input  logic [REG_W-1:0]     rs2_addr,
  output logic                 rs1_b,
  output logic                 rs2_b,
  output logic [ROB_TAG_W-1:0] rs1_tag,
  output logic [ROB_TAG_W-1:0] rs2_tag,
  input  logic                 ren,
  input  logic [REG_W-1:0]     ren_rd,
  input  logic [ROB_TAG_W-1:0] ren_tag,
  input  logic                 cmt,
  input  logic [REG_W-1:0]     cmt_rd,
  input  logic [ROB_TAG_W-1:0] head
);
  logic [NREG-1:0]                busy;
  logic [NREG-1:0][ROB_TAG_W-1:0] tag;

  // A retiring head that is still the youngest writer makes the value readable now.
  assign rs1_b   = !busy[rs1_addr] || (cmt && cmt_rd == rs1_addr && tag[rs1_addr] == head);
  assign rs2_b   = !busy[rs2_addr] || (cmt && cmt_rd == rs2_addr && tag[rs2_addr] == head);
  assign rs1_tag = tag[rs1_addr];
  assign rs2_tag = tag[rs2_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
      tag  <= '0;
    end else if (clr) begin
      busy <= '0;
    end else begin
      if (cmt && tag[cmt_rd] == head) busy[cmt_rd] <= 1'b0;
      // Rename is written last so it wins over a same-register commit clear.
      if (ren) begin
        busy[ren_rd] <= 1'b1;
        tag[ren_rd]  <= ren_tag;
      end
    end
  end
endmodule

// File: rtl/tomasulo_issue_unit.sv
// In-order issue stage: ROB tag allocation, source renaming and RS strobe.
// Define ISSUE_FLUSH_EN to add the flush input that empties ROB and rename state.
module tomasulo_issue_unit
  import tomasulo_pkg::*;
#(
  parameter int NREG      = 16,
  parameter int ROB_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iq_valid,
  output logic                 iq_ready,
  input  logic [3:0]           iq_func,
  input  logic [REG_W-1:0]     iq_rd,
  input  logic [REG_W-1:0]     iq_rs1,
  input  logic [REG_W-1:0]     iq_rs2,
  input  logic                 add_full,
  input  logic                 mul_full,
  input  logic                 commit_valid,
  input  logic [REG_W-1:0]     commit_rd,
`ifdef ISSUE_FLUSH_EN
  input  logic                 flush,
`endif
  output logic                 count,
  output logic [3:0]           func,
  output logic [REG_W-1:0]     rd,
  output logic [REG_W-1:0]     rs1,
  output logic [REG_W-1:0]     rs2,
  output logic                 rs1_b,
  output logic                 rs2_b,
  output logic [ROB_TAG_W-1:0] rob_ind,
  output logic                 rob_full
);
  localparam int OCC_W = $clog2(ROB_DEPTH + 1);

  logic [ROB_TAG_W-1:0] head, tail;
  logic [OCC_W-1:0]     occ, occ_nxt;
  logic                 legal, fire, cmt, clr;
  logic                 src1_b, src2_b;
  logic [ROB_TAG_W-1:0] src1_tag, src2_tag;

  function automatic logic [ROB_TAG_W-1:0] tag_inc(input logic [ROB_TAG_W-1:0] t);
    return (t == ROB_TAG_W'(ROB_DEPTH - 1)) ? '0 : t + 1'b1;
  endfunction

`ifdef ISSUE_FLUSH_EN
  assign clr = flush;
`else
  assign clr = 1'b0;
`endif

  // Illegal opcodes are drained from the queue without touching the ROB.
  assign legal    = is_legal(iq_func);
  assign iq_ready = !legal || (!rob_full && !(is_add_class(iq_func) && add_full) &&
                               !(is_mul_class(iq_func) && mul_full));
  assign fire     = iq_valid && iq_ready && legal;
  assign cmt      = commit_valid && occ != '0;

  always_comb begin
    occ_nxt = occ;
    if (fire && !cmt)      occ_nxt = occ + 1'b1;
    else if (cmt && !fire) occ_nxt = occ - 1'b1;
  end

  reg_status_table #(.NREG(NREG)) u_rst (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .rs1_addr (iq_rs1),
    .rs2_addr (iq_rs2),
    .rs1_b    (src1_b),
    .rs2_b    (src2_b),
    .rs1_tag  (src1_tag),
    .rs2_tag  (src2_tag),
    .ren      (fire && writes_rd(iq_func)),
    .ren_rd   (iq_rd),
    .ren_tag  (tail),
    .cmt      (cmt),
    .cmt_rd   (commit_rd),
    .head     (head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      occ      <= '0;
      rob_full <= 1'b0;
      count    <= 1'b0;
      func     <= '0;
      rd       <= '0;
      rs1      <= '0;
      rs2      <= '0;
      rs1_b    <= 1'b0;
      rs2_b    <= 1'b0;
      rob_ind  <= '0;
    end else if (clr) begin
      tail     <= head;
      occ      <= '0;
      rob_full <= 1'b0;
      count    <= 1'b0;
    end else begin
      count    <= fire;
      occ      <= occ_nxt;
      rob_full <= (occ_nxt == OCC_W'(ROB_DEPTH));
      if (cmt) head <= tag_inc(head);
      if (fire) begin
        tail    <= tag_inc(tail);
        func    <= iq_func;
        rd      <= iq_rd;
        rs1     <= src1_b ? iq_rs1 : REG_W'(src1_tag);
        rs2     <= src2_b ? iq_rs2 : REG_W'(src2_tag);
        rs1_b   <= src1_b;
        rs2_b   <= src2_b;
        rob_ind <= tail;
      end
    end
  end
endmodule

// File: doc/tomasulo_issue_unit.md
Name: tomasulo_issue_unit

Overview:
Front-end issue stage directly upstream of the reservation-station append logic. It accepts decoded instructions from the instruction queue, allocates an in-order ROB tag, and renames source registers through a register status table (busy bit plus ROB tag per architectural register). It presents a one-cycle issue strobe with func, rd, renamed sources, availability bits and ROB index to the add/mul reservation stations, and stalls on ROB-full or target-RS-full.

Parameters:
NREG, 16, architectural registers (index width 4)
ROB_DEPTH, 8, ROB entries (tag width 3)

Ports:
clk  in  1  single system clock, all state on posedge
rst  in  1  asynchronous, active-high reset
iq_valid  in  1  instruction queue holds an instruction
iq_ready  out  1  issue unit accepts this cycle (combinational)
iq_func  in  4  opcode: 0000 add, 0001 sub, 0010 mul, 0011 div, 0100 load, 0101 store, 0110/0111 branch
iq_rd  in  4  destination register
iq_rs1  in  4  source register 1
iq_rs2  in  4  source register 2
add_full  in  1  add/branch/load-store RS has no free slot
mul_full  in  1  mul/div RS has no free slot
commit_valid  in  1  ROB retires its head entry this cycle
commit_rd  in  4  destination of retiring entry
count  out  1  issue strobe to RS, high exactly one cycle per issued instruction
func  out  4  issued opcode
rd  out  4  issued destination
rs1  out  4  register number if rs1_b=1, else producing ROB tag zero-extended
rs2  out  4  as rs1 for source 2
rs1_b  out  1  1 = source 1 available in register file
rs2_b  out  1  1 = source 2 available
rob_ind  out  3  ROB tag allocated to issued instruction
rob_full  out  1  ROB occupancy == ROB_DEPTH

Behaviour:
- Reset: all outputs 0; head=tail=occupancy=0; all busy bits 0, all tags 0.
- Class: add-class = add, sub, branch, load, store; mul-class = mul, div. Writes-rd = add, sub, mul, div, load.
- iq_ready = !rob_full && !(add-class && add_full) && !(mul-class && mul_full); illegal opcodes (1000-1111) are always ready.
- Fire = iq_valid && iq_ready with legal opcode: next edge registers func/rd/rob_ind=tail, rs fields, count=1; tail <= tail+1 mod ROB_DEPTH; occupancy+1. Latency fire->count = 1 cycle; count drops next cycle unless another fire.
- Source lookup: rsX_b = !busy[rsX] || (commit_valid && commit_rd==rsX && tag[rsX]==head); when not available, rsX output = {1'b0, tag[rsX]}.
- Sources read before destination rename: rs1==rd reads the old mapping.
- Rename on fire of writes-rd op: busy[rd]<=1, tag[rd]<=tail. Store/branch leave table unchanged.
- Commit: head <= head+1 mod ROB_DEPTH, occupancy-1; clear busy[commit_rd] only if tag[commit_rd]==head (no younger writer). Commit with occupancy 0 is ignored.
- Simultaneous fire and commit: occupancy unchanged; if same rd, rename wins (busy stays 1, new tag).
- Illegal opcode: consumed (iq_ready=1), no ROB allocation, count stays 0.
- rob_full is registered from occupancy; issue blocked at 8, resumes the cycle after a commit.
- Reset mid-operation clears everything immediately; no pending strobe survives.

Optional Feature:
ISSUE_FLUSH_EN: adds input flush (1 bit). When high at an edge: all busy bits cleared, tail<=head+... set to head, occupancy<=0, count<=0; flush overrides same-cycle fire and commit. Without the macro there is no flush port and ROB state changes only by issue/commit.

Decomposition:
Shared package tomasulo_pkg: opcode constants (OP_ADD..OP_BR1), REG_W=4, ROB_TAG_W=3, class-decode function (is_add_class, is_mul_class, writes_rd). One sub-module natural: reg_status_table (busy/tag array with two read ports, one rename write, one commit clear, ordering rule built in).

Test Plan:
- Reset then issue add r3,r1,r2 -> next cycle count=1, rob_ind=0, rs1_b=rs2_b=1, rs1=1, rs2=2; busy[3]=1 tag 0.
- Then mul r4,r3,r3 -> rs1_b=rs2_b=0, rs1=rs2=4'b0000 (tag 0), rob_ind=1.
- Issue 8 writes without commit -> 9th held with iq_ready=0, rob_full=1; commit_valid one cycle -> issue resumes, rob_ind wraps to 0.
- add r5 (tag 2) then add r5 (tag 3), commit tag 2 with rd=5 -> busy[5] remains 1, tag 3; later sub r6,r5,r5 shows rs1=3.
- Commit of r3 (tag=head) same cycle as issuing sub r7,r3,r1 -> rs1_b=1, rs1=3.
- add_full=1 with mul queued -> mul issues; with add queued -> iq_ready=0, count=0; opcode 1010 -> consumed, no strobe, tail unchanged.
